// File: rtl/mem_bus_ctrl_if.sv
// CPU load/store request bus: req/we/addr/wdata/bytemode held by the master until a one-cycle ack.
// rdata is valid with ack and held by the controller until the next read completes.
interface mem_bus_ctrl_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [4:0]  bytemode;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, bytemode, input ack, rdata);
  modport slave  (input req, we, addr, wdata, bytemode, output ack, rdata);
endinterface

// File: rtl/mem_bus_ctrl.sv
// Multi-cycle controller for banked SRAM, UART (only with MEM_BUS_UART_EN) and LED/display registers.
// Latency to ack: SRAM WAIT_CYCLES+2, UART UART_PULSE+1, MMIO 1; requester holds req until ack.
module mem_bus_ctrl #(
  parameter int BANKS       = 2,
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 1,
  parameter int UART_PULSE  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  mem_bus_ctrl_if.slave       bus,
  output logic [ADDR_W-1:0]   sram_addr,
  input  logic [32*BANKS-1:0] sram_dq_i,
  output logic [31:0]         sram_dq_o,
  output logic [BANKS-1:0]    sram_dq_oe,
  output logic [3:0]          sram_be_n,
  output logic [BANKS-1:0]    sram_ce_n,
  output logic                sram_oe_n,
  output logic                sram_we_n,
  output logic                uart_rdn,
  output logic                uart_wrn,
  input  logic                uart_dataready,
  input  logic                uart_tbre,
  input  logic                uart_tsre,
  output logic [15:0]         leds,
  output logic [7:0]          dpys
);

  localparam int BW = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam logic [31:0] A_UDAT  = 32'hBFD003F8;
  localparam logic [31:0] A_USTAT = 32'hBFD003FC;
  localparam logic [31:0] A_LED   = 32'hBFD00400;
  localparam logic [31:0] A_DPY   = 32'hBFD00408;

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, UPULSE, DONE} state_t;
  typedef enum logic [1:0] {K_SRAM, K_UART, K_MMIO} kind_t;
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  bm;
  } req_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  req_t             req_q, cur;
  kind_t            kind;
  logic [BW-1:0]    bank_sel;
  logic [BANKS-1:0] bank_oh, ce_n_d, dq_oe_d;
  logic [31:0]      bank_rd, rd_ext, wr_rep, mmio_rd;
  logic             accept, last_access, sx, oe_n_d, we_n_d;

  // Outputs for the first cycle are computed from the live inputs while IDLE, later from the latched copy.
  assign accept      = (state_q == IDLE) && bus.req;
  assign cur         = (state_q == IDLE) ? {bus.we, bus.addr, bus.wdata, bus.bytemode} : req_q;
  assign last_access = (state_q == ACCESS) && (cnt_q == 4'(WAIT_CYCLES - 1));
  assign sx          = ~cur.bm[4];

  always_comb begin
    kind = K_SRAM;
    if (cur.addr == A_LED || cur.addr == A_DPY || cur.addr == A_USTAT) kind = K_MMIO;
`ifdef MEM_BUS_UART_EN
    else if (cur.addr == A_UDAT) kind = K_UART;
`else
    else if (cur.addr == A_UDAT) kind = K_MMIO;
`endif
  end

  generate
    if (BANKS > 1) begin : g_bank
      assign bank_sel = cur.addr[ADDR_W+2 +: BW];
    end else begin : g_nobank
      assign bank_sel = '0;
    end
  endgenerate

  always_comb begin
    bank_oh = '0;
    bank_rd = '0;
    for (int b = 0; b < BANKS; b++) begin
      if (bank_sel == BW'(b)) begin
        bank_oh[b] = 1'b1;
        bank_rd    = sram_dq_i[32*b +: 32];
      end
    end
  end

  // Lane masks other than single bytes and aligned halves fall through to a full word.
  always_comb begin
    rd_ext = bank_rd;
    wr_rep = cur.wdata;
    case (cur.bm[3:0])
      4'b0001: begin rd_ext = {{24{sx & bank_rd[7]}},  bank_rd[7:0]};   wr_rep = {4{cur.wdata[7:0]}}; end
      4'b0010: begin rd_ext = {{24{sx & bank_rd[15]}}, bank_rd[15:8]};  wr_rep = {4{cur.wdata[7:0]}}; end
      4'b0100: begin rd_ext = {{24{sx & bank_rd[23]}}, bank_rd[23:16]}; wr_rep = {4{cur.wdata[7:0]}}; end
      4'b1000: begin rd_ext = {{24{sx & bank_rd[31]}}, bank_rd[31:24]}; wr_rep = {4{cur.wdata[7:0]}}; end
      4'b0011: begin rd_ext = {{16{sx & bank_rd[15]}}, bank_rd[15:0]};  wr_rep = {2{cur.wdata[15:0]}}; end
      4'b1100: begin rd_ext = {{16{sx & bank_rd[31]}}, bank_rd[31:16]}; wr_rep = {2{cur.wdata[15:0]}}; end
      default: ;
    endcase
  end

`ifdef MEM_BUS_UART_EN
  logic rdn_d, wrn_d, last_pulse;
  assign last_pulse = (state_q == UPULSE) && (cnt_q == 4'(UART_PULSE - 1));
  assign mmio_rd    = (cur.addr == A_USTAT) ? {30'b0, uart_dataready, uart_tbre & uart_tsre} : 32'b0;
`else
  logic unused_uart;
  assign unused_uart = ^{uart_dataready, uart_tbre, uart_tsre, 4'(UART_PULSE)};
  assign mmio_rd     = 32'b0;
  assign uart_rdn    = 1'b1;
  assign uart_wrn    = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          cnt_d = '0;
          case (kind)
            K_SRAM:  state_d = SETUP;
            K_UART:  state_d = UPULSE;
            default: state_d = DONE;
          endcase
        end
      end
      SETUP:  begin state_d = ACCESS; cnt_d = '0; end
      ACCESS: begin
        if (last_access) state_d = DONE;
        else             cnt_d   = cnt_q + 4'd1;
      end
`ifdef MEM_BUS_UART_EN
      UPULSE: begin
        if (last_pulse) state_d = DONE;
        else            cnt_d   = cnt_q + 4'd1;
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobe values for the state being entered, so every strobe leaves a flop.
  always_comb begin
    ce_n_d  = '1;
    dq_oe_d = '0;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
`ifdef MEM_BUS_UART_EN
    rdn_d   = 1'b1;
    wrn_d   = 1'b1;
    if (kind == K_UART) begin
      if (cur.we) begin
        if (state_d inside {UPULSE, DONE}) dq_oe_d[0] = 1'b1;
        if (state_d == UPULSE) wrn_d = 1'b0;
      end else if (state_d == UPULSE) begin
        rdn_d = 1'b0;
      end
    end
`endif
    if (kind == K_SRAM) begin
      if (cur.we) begin
        if (state_d inside {SETUP, ACCESS, DONE}) begin
          ce_n_d  = ~bank_oh;
          dq_oe_d = bank_oh;
        end
        if (state_d == ACCESS) we_n_d = 1'b0;
      end else if (state_d inside {SETUP, ACCESS}) begin
        ce_n_d = ~bank_oh;
        oe_n_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sram_ce_n  <= '1;
      sram_dq_oe <= '0;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      bus.ack    <= 1'b0;
    end else begin
      sram_ce_n  <= ce_n_d;
      sram_dq_oe <= dq_oe_d;
      sram_oe_n  <= oe_n_d;
      sram_we_n  <= we_n_d;
      bus.ack    <= (state_d == DONE);
    end
  end

`ifdef MEM_BUS_UART_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      uart_rdn <= 1'b1;
      uart_wrn <= 1'b1;
    end else begin
      uart_rdn <= rdn_d;
      uart_wrn <= wrn_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q     <= '0;
      sram_addr <= '0;
      sram_be_n <= '1;
      sram_dq_o <= '0;
      bus.rdata <= '0;
      leds      <= '0;
      dpys      <= '0;
    end else begin
      if (accept) begin
        req_q <= cur;
        if (kind == K_SRAM) begin
          sram_addr <= cur.addr[ADDR_W+1:2];
          sram_be_n <= ~cur.bm[3:0];
          if (cur.we) sram_dq_o <= wr_rep;
        end
`ifdef MEM_BUS_UART_EN
        if (kind == K_UART && cur.we) sram_dq_o <= cur.wdata;
`endif
        if (kind == K_MMIO) begin
          if (cur.we) begin
            if (cur.addr == A_LED) leds <= cur.wdata[15:0];
            if (cur.addr == A_DPY) dpys <= cur.wdata[7:0];
          end else begin
            bus.rdata <= mmio_rd;
          end
        end
      end
      if (last_access && !req_q.we) bus.rdata <= rd_ext;
`ifdef MEM_BUS_UART_EN
      if (last_pulse && !req_q.we) bus.rdata <= {24'b0, sram_dq_i[7:0]};
`endif
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Vector-table bench for mem_bus_ctrl with an expected-result queue, plus reset corner sequences.
module tb_mem_bus_ctrl;
  localparam int BANKS       = 2;
  localparam int ADDR_W      = 20;
  localparam int WAIT_CYCLES = 1;
  localparam int UART_PULSE  = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mem_bus_ctrl_if bus_if ();
  logic [ADDR_W-1:0]   sram_addr;
  logic [32*BANKS-1:0] sram_dq_i;
  logic [31:0]         sram_dq_o;
  logic [BANKS-1:0]    sram_dq_oe, sram_ce_n;
  logic [3:0]          sram_be_n;
  logic                sram_oe_n, sram_we_n, uart_rdn, uart_wrn;
  logic                uart_dataready, uart_tbre, uart_tsre;
  logic [15:0]         leds;
  logic [7:0]          dpys;

  mem_bus_ctrl #(.BANKS(BANKS), .ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES), .UART_PULSE(UART_PULSE)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus_if),
    .sram_addr(sram_addr), .sram_dq_i(sram_dq_i), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
    .sram_be_n(sram_be_n), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .uart_rdn(uart_rdn), .uart_wrn(uart_wrn), .uart_dataready(uart_dataready),
    .uart_tbre(uart_tbre), .uart_tsre(uart_tsre), .leds(leds), .dpys(dpys)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr, wdata;
    logic [4:0]  bm;
    logic [31:0] dq0, dq1;
    logic [31:0] rd;
    int          lat, ce0, ce1, wen, oen, rdn, wrn;
    logic        chk;
    logic [31:0] s_addr;
    logic [3:0]  be_n;
    logic [31:0] dqo;
    logic [1:0]  oem;
  } vec_t;

  vec_t        vecs[$];
  vec_t        sbq[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] last_rd = '0;

  function automatic vec_t mk(input logic we, input logic [31:0] addr, wdata, input logic [4:0] bm,
                              input logic [31:0] dq0, dq1, rd, input int lat, ce0, ce1, wen, oen, rdn, wrn,
                              input logic chk, input logic [31:0] s_addr, input logic [3:0] be_n,
                              input logic [31:0] dqo, input logic [1:0] oem);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.bm = bm; v.dq0 = dq0; v.dq1 = dq1; v.rd = rd;
    v.lat = lat; v.ce0 = ce0; v.ce1 = ce1; v.wen = wen; v.oen = oen; v.rdn = rdn; v.wrn = wrn;
    v.chk = chk; v.s_addr = s_addr; v.be_n = be_n; v.dqo = dqo; v.oem = oem;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic run(input int idx, input vec_t v);
    vec_t        e;
    int          lat, c0, c1, cw, co, cr, cwr;
    bit          got, multi;
    logic [31:0] a_addr, a_dq;
    logic [3:0]  a_be;
    logic [1:0]  a_oe;
    lat = 0; c0 = 0; c1 = 0; cw = 0; co = 0; cr = 0; cwr = 0; got = 0; multi = 0;
    a_addr = '0; a_dq = '0; a_be = '0; a_oe = '0;
    @(negedge clk);
    sram_dq_i        = {v.dq1, v.dq0};
    bus_if.req       = 1'b1;
    bus_if.we        = v.we;
    bus_if.addr      = v.addr;
    bus_if.wdata     = v.wdata;
    bus_if.bytemode  = v.bm;
    e = v;
    if (v.we) e.rd = last_rd;
    else      last_rd = v.rd;
    sbq.push_back(e);
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (!sram_ce_n[0]) c0++;
      if (!sram_ce_n[1]) c1++;
      if (!sram_we_n)    cw++;
      if (!sram_oe_n)    co++;
      if (!uart_rdn)     cr++;
      if (!uart_wrn)     cwr++;
      if (sram_ce_n == 2'b00) multi = 1;
      if (!sram_we_n) begin a_addr = 32'(sram_addr); a_be = sram_be_n; a_dq = sram_dq_o; a_oe = sram_dq_oe; end
      if (!sram_oe_n) begin a_addr = 32'(sram_addr); a_be = sram_be_n; end
      if (bus_if.ack) got = 1;
    end
    bus_if.req = 1'b0;
    e = sbq.pop_front();
    check($sformatf("v%0d_ack_seen", idx), 32'(got), 32'd1);
    check($sformatf("v%0d_rdata", idx), bus_if.rdata, e.rd);
    check($sformatf("v%0d_latency", idx), 32'(lat), 32'(e.lat));
    check($sformatf("v%0d_ce0_cycles", idx), 32'(c0), 32'(e.ce0));
    check($sformatf("v%0d_ce1_cycles", idx), 32'(c1), 32'(e.ce1));
    check($sformatf("v%0d_we_cycles", idx), 32'(cw), 32'(e.wen));
    check($sformatf("v%0d_oe_cycles", idx), 32'(co), 32'(e.oen));
    check($sformatf("v%0d_rdn_cycles", idx), 32'(cr), 32'(e.rdn));
    check($sformatf("v%0d_wrn_cycles", idx), 32'(cwr), 32'(e.wrn));
    check($sformatf("v%0d_one_bank", idx), 32'(multi), 32'd0);
    if (e.chk) begin
      check($sformatf("v%0d_sram_addr", idx), a_addr, e.s_addr);
      check($sformatf("v%0d_be_n", idx), 32'(a_be), 32'(e.be_n));
      if (e.we) begin
        check($sformatf("v%0d_dq_o", idx), a_dq, e.dqo);
        check($sformatf("v%0d_dq_oe", idx), 32'(a_oe), 32'(e.oem));
      end
    end
    @(negedge clk);
    check($sformatf("v%0d_ack_pulse", idx), 32'(bus_if.ack), 32'd0);
    check($sformatf("v%0d_idle_strobes", idx), 32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'hF);
    check($sformatf("v%0d_rdata_hold", idx), bus_if.rdata, e.rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  initial begin
    int  n;
    bit  saw_ack;
    bus_if.req = 1'b0; bus_if.we = 1'b0; bus_if.addr = '0; bus_if.wdata = '0; bus_if.bytemode = '0;
    sram_dq_i = '0; uart_dataready = 1'b1; uart_tbre = 1'b1; uart_tsre = 1'b0;

    // we, addr, wdata, bm, dq0, dq1, rd, lat, ce0, ce1, we, oe, rdn, wrn, chk, s_addr, be_n, dq_o, dq_oe
    vecs.push_back(mk(1, 32'h00000010, 32'h12345678, 5'b01111, 32'h0, 32'h0, 32'h0, 3, 3, 0, 1, 0, 0, 0, 1, 32'h4, 4'b0000, 32'h12345678, 2'b01));
    vecs.push_back(mk(0, 32'h00400013, 32'h0, 5'b01000, 32'h11111111, 32'h80AABBCC, 32'hFFFFFF80, 3, 0, 2, 0, 2, 0, 0, 1, 32'h4, 4'b0111, 32'h0, 2'b00));
    vecs.push_back(mk(0, 32'h00400013, 32'h0, 5'b11000, 32'h11111111, 32'h80AABBCC, 32'h00000080, 3, 0, 2, 0, 2, 0, 0, 1, 32'h4, 4'b0111, 32'h0, 2'b00));
    vecs.push_back(mk(0, 32'h00000020, 32'h0, 5'b00011, 32'h1234F00D, 32'hFFFFFFFF, 32'hFFFFF00D, 3, 2, 0, 0, 2, 0, 0, 1, 32'h8, 4'b1100, 32'h0, 2'b00));
    vecs.push_back(mk(0, 32'h00000024, 32'h0, 5'b11100, 32'h80010000, 32'hFFFFFFFF, 32'h00008001, 3, 2, 0, 0, 2, 0, 0, 1, 32'h9, 4'b0011, 32'h0, 2'b00));
    vecs.push_back(mk(0, 32'h00000028, 32'h0, 5'b00101, 32'hDEADBEEF, 32'hFFFFFFFF, 32'hDEADBEEF, 3, 2, 0, 0, 2, 0, 0, 1, 32'hA, 4'b1010, 32'h0, 2'b00));
    vecs.push_back(mk(0, 32'h0000002C, 32'h0, 5'b00010, 32'h00007F00, 32'hFFFFFFFF, 32'h0000007F, 3, 2, 0, 0, 2, 0, 0, 1, 32'hB, 4'b1101, 32'h0, 2'b00));
    vecs.push_back(mk(1, 32'h0040000A, 32'h000000AB, 5'b00100, 32'h0, 32'h0, 32'h0, 3, 0, 3, 1, 0, 0, 0, 1, 32'h2, 4'b1011, 32'hABABABAB, 2'b10));
    vecs.push_back(mk(1, 32'h00000032, 32'h0000BEEF, 5'b01100, 32'h0, 32'h0, 32'h0, 3, 3, 0, 1, 0, 0, 0, 1, 32'hC, 4'b0011, 32'hBEEFBEEF, 2'b01));
    vecs.push_back(mk(1, 32'hBFD00400, 32'h0000A5A5, 5'b01111, 32'h0, 32'h0, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 4'b0, 32'h0, 2'b00));
    vecs.push_back(mk(1, 32'hBFD00408, 32'h12345678, 5'b01111, 32'h0, 32'h0, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 4'b0, 32'h0, 2'b00));
    vecs.push_back(mk(0, 32'hBFD00400, 32'h0, 5'b01111, 32'h55555555, 32'h55555555, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 4'b0, 32'h0, 2'b00));
`ifdef MEM_BUS_UART_EN
    vecs.push_back(mk(0, 32'hBFD003FC, 32'h0, 5'b01111, 32'h0, 32'h0, 32'h00000002, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 4'b0, 32'h0, 2'b00));
    vecs.push_back(mk(0, 32'hBFD003F8, 32'h0, 5'b01111, 32'h12345641, 32'hFFFFFFFF, 32'h00000041, 3, 0, 0, 0, 0, 2, 0, 0, 32'h0, 4'b0, 32'h0, 2'b00));
    vecs.push_back(mk(1, 32'hBFD003F8, 32'h00000055, 5'b01111, 32'h0, 32'h0, 32'h0, 3, 0, 0, 0, 0, 0, 2, 0, 32'h0, 4'b0, 32'h0, 2'b00));
`else
    vecs.push_back(mk(0, 32'hBFD003FC, 32'h0, 5'b01111, 32'h0, 32'h0, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 4'b0, 32'h0, 2'b00));
    vecs.push_back(mk(0, 32'hBFD003F8, 32'h0, 5'b01111, 32'h12345641, 32'hFFFFFFFF, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 4'b0, 32'h0, 2'b00));
    vecs.push_back(mk(1, 32'hBFD003F8, 32'h00000055, 5'b01111, 32'h0, 32'h0, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 4'b0, 32'h0, 2'b00));
`endif

    repeat (2) @(negedge clk);
    check("rst_ack", 32'(bus_if.ack), 32'd0);
    check("rst_rdata", bus_if.rdata, 32'd0);
    check("rst_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, uart_rdn, uart_wrn}), 32'h3F);
    check("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
    check("rst_sram_addr", 32'(sram_addr), 32'd0);
    check("rst_dq_o", sram_dq_o, 32'd0);
    check("rst_leds_dpys", 32'({leds, dpys}), 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      run(i, vecs[i]);
      if (vecs[i].addr == 32'hBFD00400 && vecs[i].we) check("leds_written", 32'(leds), 32'h0000A5A5);
      if (vecs[i].addr == 32'hBFD00408 && vecs[i].we) check("dpys_written", 32'(dpys), 32'h00000078);
    end

    // Reset during the write strobe: strobes must drop at once and no ack may follow.
    @(negedge clk);
    bus_if.req = 1'b1; bus_if.we = 1'b1; bus_if.addr = 32'h00000040;
    bus_if.wdata = 32'hCAFEF00D; bus_if.bytemode = 5'b01111;
    n = 0;
    while (sram_we_n && n < 10) begin @(negedge clk); n++; end
    check("midrst_reached_access", 32'(sram_we_n), 32'd0);
    reset_n = 1'b0;
    #1;
    check("midrst_we_n", 32'(sram_we_n), 32'd1);
    check("midrst_ce_n", 32'(sram_ce_n), 32'h3);
    check("midrst_dq_oe", 32'(sram_dq_oe), 32'd0);
    bus_if.req = 1'b0;
    saw_ack = 0;
    repeat (3) begin @(negedge clk); if (bus_if.ack) saw_ack = 1; end
    reset_n = 1'b1;
    repeat (2) begin @(negedge clk); if (bus_if.ack) saw_ack = 1; end
    check("midrst_no_ack", 32'(saw_ack), 32'd0);
    check("midrst_leds_cleared", 32'(leds), 32'd0);
    last_rd = '0;
    run(100, vecs[3]);
    run(101, vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
